pipe_sel_reg: RTL and testbench

PIPE_SEL_REG -- requirements
Module: pipe_sel_reg

---
 rtl/pipe_sel_reg.sv | 190 +++++++++++++++++++
 tb/tb_pipe_sel_reg.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_sel_reg.sv
// pipe_sel_reg: registered N-way word selector with valid/ready handshake.
// Captures in_data[sel*WIDTH +: WIDTH] on each input transfer and presents it
// one cycle later on out_data. Out-of-range selects capture zero and raise
// sel_err alongside that word. A synchronous flush empties the stage.
// Optional feature macro: PIPE_SEL_SKID_EN adds a one-entry skid buffer and
// turns in_ready into a registered signal.
module pipe_sel_reg #(
    parameter int WIDTH  = 6,
    parameter int NUM_IN = 2,
    parameter int SEL_W  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    // Returns {err, word}: err set and word zero when idx names no input.
    function automatic logic [WIDTH:0] pick_word(
        input logic [NUM_IN*WIDTH-1:0] data,
        input logic [SEL_W-1:0]        idx
    );
        logic [WIDTH:0] res;
        res = {1'b1, {WIDTH{1'b0}}};
        for (int i = 0; i < NUM_IN; i++) begin
            if (int'(idx) == i) begin
                res = {1'b0, data[i*WIDTH +: WIDTH]};
            end
        end
        return res;
    endfunction

    state_t             state_r;
    state_t             state_s;
    logic [WIDTH-1:0]   out_data_r;
    logic [WIDTH-1:0]   out_data_s;
    logic               sel_err_r;
    logic               sel_err_s;
    logic               out_valid_r;
    logic               out_valid_s;
    logic [WIDTH:0]     cap_s;
    logic               in_fire_s;

`ifdef PIPE_SEL_SKID_EN
    logic [WIDTH-1:0]   skid_data_r;
    logic [WIDTH-1:0]   skid_data_s;
    logic               skid_err_r;
    logic               skid_err_s;
    logic               in_ready_r;
    logic               in_ready_s;

    // Ready comes from a register so upstream timing is isolated; a flush
    // cycle still refuses the offered word.
    assign in_ready = in_ready_r & ~flush;
`else
    // Without skid storage the stage can only accept when its single entry
    // is free or leaving this cycle.
    assign in_ready = (~out_valid_r | out_ready) & ~flush & rst;
`endif

    assign cap_s     = pick_word(in_data, sel);
    assign in_fire_s = in_valid & in_ready;

    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign sel_err   = sel_err_r;

    // Next-state and next-datapath decode for the EMPTY/FULL(/SKID) control.
    always_comb begin
        state_s     = state_r;
        out_data_s  = out_data_r;
        sel_err_s   = sel_err_r;
`ifdef PIPE_SEL_SKID_EN
        skid_data_s = skid_data_r;
        skid_err_s  = skid_err_r;
`endif
        if (flush) begin
            state_s    = ST_EMPTY;
            out_data_s = {WIDTH{1'b0}};
            sel_err_s  = 1'b0;
`ifdef PIPE_SEL_SKID_EN
            skid_data_s = {WIDTH{1'b0}};
            skid_err_s  = 1'b0;
`endif
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        state_s    = ST_FULL;
                        out_data_s = cap_s[WIDTH-1:0];
                        sel_err_s  = cap_s[WIDTH];
                    end else begin
                        state_s    = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        if (in_fire_s) begin
                            // Output leaves and the new word replaces it: no bubble.
                            state_s    = ST_FULL;
                            out_data_s = cap_s[WIDTH-1:0];
                            sel_err_s  = cap_s[WIDTH];
                        end else begin
                            state_s    = ST_EMPTY;
                        end
                    end else begin
`ifdef PIPE_SEL_SKID_EN
                        if (in_fire_s) begin
                            state_s     = ST_SKID;
                            skid_data_s = cap_s[WIDTH-1:0];
                            skid_err_s  = cap_s[WIDTH];
                        end else begin
                            state_s     = ST_FULL;
                        end
`else
                        state_s = ST_FULL;
`endif
                    end
                end
`ifdef PIPE_SEL_SKID_EN
                ST_SKID: begin
                    if (out_ready) begin
                        // Skid word is older than anything upstream; promote it.
                        state_s     = ST_FULL;
                        out_data_s  = skid_data_r;
                        sel_err_s   = skid_err_r;
                        skid_data_s = {WIDTH{1'b0}};
                        skid_err_s  = 1'b0;
                    end else begin
                        state_s     = ST_SKID;
                    end
                end
`endif
                default: begin
                    state_s    = ST_EMPTY;
                    out_data_s = {WIDTH{1'b0}};
                    sel_err_s  = 1'b0;
                end
            endcase
        end
        out_valid_s = (state_s != ST_EMPTY);
`ifdef PIPE_SEL_SKID_EN
        in_ready_s  = (state_s != ST_SKID);
`endif
    end

    // State and output registers; reset empties the stage immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_EMPTY;
            out_data_r  <= {WIDTH{1'b0}};
            sel_err_r   <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            out_data_r  <= out_data_s;
            sel_err_r   <= sel_err_s;
            out_valid_r <= out_valid_s;
        end
    end

`ifdef PIPE_SEL_SKID_EN
    // Skid entry and registered ready; ready stays low until the first edge out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skid_data_r <= {WIDTH{1'b0}};
            skid_err_r  <= 1'b0;
            in_ready_r  <= 1'b0;
        end else begin
            skid_data_r <= skid_data_s;
            skid_err_r  <= skid_err_s;
            in_ready_r  <= in_ready_s;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_sel_reg.sv
// Self-checking bench for pipe_sel_reg. Two instances share stimulus:
// a 4-input one and a 3-input one (so select value 3 is out of range there).
// The reference model is a word FIFO with capacity 1 (2 with skid).
module tb_pipe_sel_reg;

    logic        clk;
    logic        rst;
    logic [23:0] in_data;
    logic [1:0]  sel;
    logic        in_valid;
    logic        flush;
    logic        out_ready;

    logic        in_ready4, out_valid4, sel_err4;
    logic [5:0]  out_data4;
    logic        in_ready3, out_valid3, sel_err3;
    logic [5:0]  out_data3;
    logic [17:0] in_data3;

    assign in_data3 = in_data[17:0];

    pipe_sel_reg #(.WIDTH(6), .NUM_IN(4), .SEL_W(2)) dut4 (
        .clk(clk), .rst(rst), .in_data(in_data), .sel(sel), .in_valid(in_valid),
        .in_ready(in_ready4), .flush(flush), .out_data(out_data4),
        .out_valid(out_valid4), .out_ready(out_ready), .sel_err(sel_err4)
    );

    pipe_sel_reg #(.WIDTH(6), .NUM_IN(3), .SEL_W(2)) dut3 (
        .clk(clk), .rst(rst), .in_data(in_data3), .sel(sel), .in_valid(in_valid),
        .in_ready(in_ready3), .flush(flush), .out_data(out_data3),
        .out_valid(out_valid3), .out_ready(out_ready), .sel_err(sel_err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] d4;
        logic       e4;
        logic [5:0] d3;
        logic       e3;
    } ent_t;

    ent_t q[$];
    bit   m_ready_r;
    int   n_vec;
    int   n_err;

    function automatic bit model_ready();
`ifdef PIPE_SEL_SKID_EN
        return m_ready_r && !flush && rst;
`else
        return (q.size() == 0 || out_ready) && !flush && rst;
`endif
    endfunction

    function automatic ent_t model_word();
        ent_t        e;
        logic [23:0] sh;
        sh   = in_data >> (int'(sel) * 6);
        e.d4 = sh[5:0];
        e.e4 = 1'b0;
        e.d3 = (sel < 2'd3) ? sh[5:0] : 6'h00;
        e.e3 = (sel == 2'd3);
        return e;
    endfunction

    // One clock edge: the model decides acceptance from its own ready.
    task automatic tick(output bit acc);
        ent_t e;
        bit   pop;
        acc = rst && in_valid && model_ready();
        e   = model_word();
        pop = rst && !flush && q.size() > 0 && out_ready;
        @(posedge clk);
        if (!rst) begin
            q.delete();
            m_ready_r = 1'b0;
        end else if (flush) begin
            q.delete();
            m_ready_r = 1'b1;
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(e);
            m_ready_r = (q.size() < 2);
        end
        #1;
    endtask

    task automatic test_reset();
        bit acc;
        rst = 1'b1; in_data = 24'h0; sel = 2'd0; in_valid = 1'b0;
        flush = 1'b0; out_ready = 1'b0;
        #1 rst = 1'b0;
        q.delete(); m_ready_r = 1'b0;
        #1;
        n_vec++; if (out_valid4 !== 1'b0 || out_valid3 !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b/%b want 0", out_valid4, out_valid3); end
        n_vec++; if (out_data4 !== 6'h00 || out_data3 !== 6'h00) begin n_err++; $display("FAIL reset_out_data: got %h/%h want 00", out_data4, out_data3); end
        n_vec++; if (sel_err4 !== 1'b0 || sel_err3 !== 1'b0) begin n_err++; $display("FAIL reset_sel_err: got %b/%b want 0", sel_err4, sel_err3); end
        n_vec++; if (in_ready4 !== 1'b0 || in_ready3 !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b/%b want 0", in_ready4, in_ready3); end
        tick(acc);
        tick(acc);
        rst = 1'b1;
        #1;
        n_vec++; if (in_ready4 !== model_ready()) begin n_err++; $display("FAIL release_in_ready: got %b want %b", in_ready4, model_ready()); end
        tick(acc);
        n_vec++; if (in_ready4 !== 1'b1 || in_ready3 !== 1'b1) begin n_err++; $display("FAIL first_edge_in_ready: got %b/%b want 1", in_ready4, in_ready3); end
        n_vec++; if (out_valid4 !== 1'b0) begin n_err++; $display("FAIL idle_out_valid: got %b want 0", out_valid4); end
    endtask

    task automatic test_select();
        bit acc;
        in_data = {6'h3F, 6'h15, 6'h2A, 6'h01}; sel = 2'd2; in_valid = 1'b1; out_ready = 1'b1;
        #1 tick(acc);
        in_valid = 1'b0;
        #1;
        n_vec++; if (out_valid4 !== 1'b1 || out_data4 !== 6'h15 || sel_err4 !== 1'b0) begin n_err++; $display("FAIL select4: got v=%b d=%h e=%b want 1 15 0", out_valid4, out_data4, sel_err4); end
        n_vec++; if (out_valid3 !== 1'b1 || out_data3 !== 6'h15 || sel_err3 !== 1'b0) begin n_err++; $display("FAIL select3: got v=%b d=%h e=%b want 1 15 0", out_valid3, out_data3, sel_err3); end
        tick(acc);
        n_vec++; if (out_valid4 !== 1'b0) begin n_err++; $display("FAIL select_drain: got %b want 0", out_valid4); end
    endtask

    task automatic test_bad_sel();
        bit acc;
        in_data = {6'h3F, 6'h15, 6'h2A, 6'h01}; sel = 2'd3; in_valid = 1'b1; out_ready = 1'b1;
        #1 tick(acc);
        sel = 2'd1;
        #1;
        n_vec++; if (out_data3 !== 6'h00 || sel_err3 !== 1'b1 || out_valid3 !== 1'b1) begin n_err++; $display("FAIL bad_sel3: got d=%h e=%b v=%b want 00 1 1", out_data3, sel_err3, out_valid3); end
        n_vec++; if (out_data4 !== 6'h3F || sel_err4 !== 1'b0) begin n_err++; $display("FAIL sel3_on4: got d=%h e=%b want 3f 0", out_data4, sel_err4); end
        tick(acc);
        in_valid = 1'b0;
        #1;
        n_vec++; if (out_data3 !== 6'h2A || sel_err3 !== 1'b0) begin n_err++; $display("FAIL after_bad_sel: got d=%h e=%b want 2a 0", out_data3, sel_err3); end
        tick(acc);
    endtask

    task automatic test_backpressure();
        bit        acc;
        bit        b_taken;
        logic [5:0] got[$];
        in_data = {18'h2A5A5, 6'h05}; sel = 2'd0; in_valid = 1'b1; out_ready = 1'b0;
        #1 tick(acc);
        in_data = {18'h13579, 6'h06};
        b_taken = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++; if (out_valid4 !== 1'b1 || out_data4 !== 6'h05) begin n_err++; $display("FAIL stall_hold: got v=%b d=%h want 1 05", out_valid4, out_data4); end
            n_vec++; if (in_ready4 !== model_ready()) begin n_err++; $display("FAIL stall_ready: got %b want %b", in_ready4, model_ready()); end
`ifdef PIPE_SEL_SKID_EN
            if (b_taken) begin
                n_vec++; if (in_ready4 !== 1'b0) begin n_err++; $display("FAIL skid_full_ready: got %b want 0", in_ready4); end
            end
`endif
            tick(acc);
            if (acc) begin b_taken = 1'b1; in_valid = 1'b0; end
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6 && got.size() < 2; i++) begin
            #1;
            if (out_valid4 === 1'b1) got.push_back(out_data4);
            tick(acc);
            if (acc) begin b_taken = 1'b1; in_valid = 1'b0; end
        end
        n_vec++; if (got.size() != 2) begin n_err++; $display("FAIL bp_count: got %0d words want 2", got.size()); end
        else begin
            n_vec++; if (got[0] !== 6'h05 || got[1] !== 6'h06) begin n_err++; $display("FAIL bp_order: got %h,%h want 05,06", got[0], got[1]); end
        end
        #1;
        n_vec++; if (out_valid4 !== 1'b0) begin n_err++; $display("FAIL bp_dup: got v=%b want 0", out_valid4); end
    endtask

    task automatic test_flush();
        bit acc;
        in_data = {18'h0, 6'h07}; sel = 2'd0; in_valid = 1'b1; out_ready = 1'b0;
        #1 tick(acc);
        in_data = {18'h0, 6'h08};
        #1 tick(acc);
        in_data = {18'h0, 6'h09}; flush = 1'b1;
        #1;
        n_vec++; if (in_ready4 !== 1'b0 || in_ready3 !== 1'b0) begin n_err++; $display("FAIL flush_ready: got %b/%b want 0", in_ready4, in_ready3); end
        tick(acc);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        n_vec++; if (out_valid4 !== 1'b0 || out_valid3 !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b/%b want 0", out_valid4, out_valid3); end
        n_vec++; if (in_ready4 !== 1'b1 || sel_err4 !== 1'b0) begin n_err++; $display("FAIL flush_after: got rdy=%b e=%b want 1 0", in_ready4, sel_err4); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(acc);
            n_vec++; if (out_valid4 !== 1'b0) begin n_err++; $display("FAIL flush_ghost: got v=%b d=%h want 0", out_valid4, out_data4); end
        end
    endtask

    task automatic test_async_reset();
        bit acc;
        in_data = {6'h3F, 6'h15, 6'h2A, 6'h01}; sel = 2'd3; in_valid = 1'b1; out_ready = 1'b0;
        #1 tick(acc);
        in_valid = 1'b0;
        #1;
        n_vec++; if (out_data4 !== 6'h3F || sel_err3 !== 1'b1) begin n_err++; $display("FAIL pre_reset: got d=%h e=%b want 3f 1", out_data4, sel_err3); end
        #1 rst = 1'b0;
        q.delete(); m_ready_r = 1'b0;
        #1;
        n_vec++; if (out_valid4 !== 1'b0 || out_valid3 !== 1'b0) begin n_err++; $display("FAIL async_valid: got %b/%b want 0", out_valid4, out_valid3); end
        n_vec++; if (out_data4 !== 6'h00 || sel_err3 !== 1'b0) begin n_err++; $display("FAIL async_data: got d=%h e=%b want 00 0", out_data4, sel_err3); end
        n_vec++; if (in_ready4 !== 1'b0) begin n_err++; $display("FAIL async_ready: got %b want 0", in_ready4); end
        #1 rst = 1'b1;
        tick(acc);
        n_vec++; if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0) begin n_err++; $display("FAIL post_reset: got rdy=%b v=%b want 1 0", in_ready4, out_valid4); end
    endtask

    task automatic test_random();
        bit acc;
        for (int i = 0; i < 400; i++) begin
            in_data   = 24'($urandom);
            sel       = 2'($urandom_range(0, 3));
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 5);
            flush     = ($urandom_range(0, 19) == 0);
            #1;
            n_vec++; if (in_ready4 !== model_ready() || in_ready3 !== model_ready()) begin n_err++; $display("FAIL rnd_ready @%0d: got %b/%b want %b", i, in_ready4, in_ready3, model_ready()); end
            n_vec++; if (out_valid4 !== (q.size() > 0) || out_valid3 !== (q.size() > 0)) begin n_err++; $display("FAIL rnd_valid @%0d: got %b/%b want %b", i, out_valid4, out_valid3, q.size() > 0); end
            if (q.size() > 0) begin
                n_vec++; if (out_data4 !== q[0].d4 || sel_err4 !== q[0].e4) begin n_err++; $display("FAIL rnd_word4 @%0d: got %h/%b want %h/%b", i, out_data4, sel_err4, q[0].d4, q[0].e4); end
                n_vec++; if (out_data3 !== q[0].d3 || sel_err3 !== q[0].e3) begin n_err++; $display("FAIL rnd_word3 @%0d: got %h/%b want %h/%b", i, out_data3, sel_err3, q[0].d3, q[0].e3); end
            end
            tick(acc);
        end
        flush = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_select();
        test_bad_sel();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
